// File: rtl/cache_tag_lookup_pkg.sv
// Shared constants and helpers for the L1 tag store and lookup pipeline.
// Defaults match the existing cache_tag geometry.
package cache_tag_lookup_pkg;

    localparam int CACHE_WAYS_DEFAULT = 4;
    localparam int CACHE_SETS_DEFAULT = 8;
    localparam int CACHE_TAG_W        = 9;
    localparam int CACHE_MAX_WAYS     = 16;

    // Index of the lowest set bit. Returns 0 when no bit is set.
    function automatic logic [3:0] lowest_set_idx(input logic [CACHE_MAX_WAYS-1:0] vec);
        lowest_set_idx = '0;
        for (int i = CACHE_MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set_idx = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/cache_tag_lookup_plru_tree.sv
// Combinational tree-PLRU for one set. Node n has children 2n+1 (lower half)
// and 2n+2 (upper half). A bit value of 1 points to the upper half.
module plru_tree #(
    parameter  int WAYS   = 4,
    localparam int WIDX_W = $clog2(WAYS),
    localparam int NODES  = WAYS - 1
) (
    input  logic [NODES-1:0]  state,
    input  logic [WIDX_W-1:0] touch_way,
    output logic [NODES-1:0]  next_state,
    output logic [WIDX_W-1:0] victim
);

    logic [NODES-1:0] reached;
    logic [NODES-1:0] reached_upper;

    assign reached_upper = reached & state;

    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_node
            localparam int LVL = $clog2(gi + 2) - 1;
            localparam int POS = gi - (2 ** LVL - 1);

            // A node lies on the victim path if its parent points toward it.
            if (gi == 0) begin : g_root
                assign reached[gi] = 1'b1;
            end else if (gi % 2 == 1) begin : g_lower
                assign reached[gi] = reached[(gi - 1) / 2] & ~state[(gi - 1) / 2];
            end else begin : g_upper
                assign reached[gi] = reached[(gi - 2) / 2] & state[(gi - 2) / 2];
            end

            // Nodes on the touched way's path are redirected to the other half.
            assign next_state[gi] = (int'(touch_way >> (WIDX_W - LVL)) == POS)
                                    ? ~touch_way[WIDX_W-1-LVL] : state[gi];
        end

        for (gi = 0; gi < WIDX_W; gi++) begin : g_level
            assign victim[WIDX_W-1-gi] = |reached_upper[2**(gi+1)-2 : 2**gi-1];
        end
    endgenerate

endmodule

// File: rtl/compare.sv
// Generic equality comparator. One instance is used per way for tag matching.
module compare #(
    parameter int width = 9
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/cache_tag_lookup.sv
// N-way tag store with a registered lookup stage, tree-PLRU replacement,
// and fill / set-invalidate write ports for the cache control FSM.
module cache_tag_lookup
    import cache_tag_lookup_pkg::*;
#(
    parameter  int WAYS   = CACHE_WAYS_DEFAULT,
    parameter  int SETS   = CACHE_SETS_DEFAULT,
    parameter  int TAG_W  = CACHE_TAG_W,
    localparam int WIDX_W = $clog2(WAYS),
    localparam int SIDX_W = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SIDX_W-1:0] req_set,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [WAYS-1:0]   resp_way,
    output logic [WIDX_W-1:0] resp_way_idx,
    output logic [WIDX_W-1:0] resp_victim,
    input  logic              fill_en,
    input  logic [SIDX_W-1:0] fill_set,
    input  logic [WIDX_W-1:0] fill_way,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic              inval_en,
    input  logic [SIDX_W-1:0] inval_set
);

    logic [TAG_W-1:0]  tag_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid_reg [SETS];
    logic [WAYS-1:0]   valid_next [SETS];
    logic [WAYS-2:0]   plru_reg [SETS];
    logic [WAYS-2:0]   plru_next [SETS];
    logic [WIDX_W-1:0] plru_victim [SETS];
    logic [WIDX_W-1:0] touch_way [SETS];

    logic [SETS-1:0]   fill_hit_set;
    logic [SETS-1:0]   inval_hit_set;
    logic [SETS-1:0]   resp_touch_set;
    logic [WAYS-1:0]   fill_onehot;

    logic              resp_valid_reg;
    logic              resp_hit_reg;
    logic [WAYS-1:0]   resp_way_reg;
    logic [WIDX_W-1:0] resp_way_idx_reg;
    logic [WIDX_W-1:0] resp_victim_reg;
    logic [SIDX_W-1:0] resp_set_reg;

    logic              req_fire;
    logic              resp_fire_hit;
    logic [WAYS-1:0]   tag_eq;
    logic [WAYS-1:0]   match;
    logic [WAYS-1:0]   lookup_invalid;
    logic [WIDX_W-1:0] lookup_idx;
    logic [WIDX_W-1:0] lookup_victim;

    // Lookups are held off whenever an array write is in progress, so the
    // combinational read below never observes a half-written set.
    assign req_ready     = !rst && !fill_en && !inval_en && (!resp_valid_reg || resp_ready);
    assign req_fire      = req_valid && req_ready;
    assign resp_fire_hit = resp_valid_reg && resp_ready && resp_hit_reg;
    assign fill_onehot   = WAYS'(1) << fill_way;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            compare #(.width(TAG_W)) u_cmp (
                .a  (tag_mem[req_set][gi]),
                .b  (req_tag),
                .eq (tag_eq[gi])
            );
        end
    endgenerate

    assign match          = tag_eq & valid_reg[req_set];
    assign lookup_invalid = ~valid_reg[req_set];
    assign lookup_idx     = WIDX_W'(lowest_set_idx(CACHE_MAX_WAYS'(match)));
    assign lookup_victim  = (|lookup_invalid)
                            ? WIDX_W'(lowest_set_idx(CACHE_MAX_WAYS'(lookup_invalid)))
                            : plru_victim[req_set];

    // Tag storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_set][fill_way] <= fill_tag;
        end
    end

    generate
        for (gi = 0; gi < SETS; gi++) begin : g_set
            localparam logic [SIDX_W-1:0] SET_ID = SIDX_W'(gi);

            assign fill_hit_set[gi]   = fill_en && (fill_set == SET_ID);
            assign inval_hit_set[gi]  = inval_en && (inval_set == SET_ID);
            assign resp_touch_set[gi] = resp_fire_hit && (resp_set_reg == SET_ID);

            // A fill touch overrides a response touch landing on the same set.
            assign touch_way[gi] = fill_hit_set[gi] ? fill_way : resp_way_idx_reg;

            // Invalidate clears first, then the fill sets its way.
            assign valid_next[gi] = (inval_hit_set[gi] ? '0 : valid_reg[gi])
                                  | (fill_hit_set[gi] ? fill_onehot : '0);

            plru_tree #(.WAYS(WAYS)) u_plru (
                .state      (plru_reg[gi]),
                .touch_way  (touch_way[gi]),
                .next_state (plru_next[gi]),
                .victim     (plru_victim[gi])
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= '0;
                    plru_reg[gi]  <= '0;
                end else begin
                    valid_reg[gi] <= valid_next[gi];
                    if (fill_hit_set[gi] || resp_touch_set[gi]) begin
                        plru_reg[gi] <= plru_next[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_reg   <= 1'b0;
            resp_hit_reg     <= 1'b0;
            resp_way_reg     <= '0;
            resp_way_idx_reg <= '0;
            resp_victim_reg  <= '0;
            resp_set_reg     <= '0;
        end else if (req_fire) begin
            resp_valid_reg   <= 1'b1;
            resp_hit_reg     <= |match;
            resp_way_reg     <= match;
            resp_way_idx_reg <= lookup_idx;
            resp_victim_reg  <= lookup_victim;
            resp_set_reg     <= req_set;
        end else if (resp_ready) begin
            resp_valid_reg   <= 1'b0;
        end
    end

    assign resp_valid   = resp_valid_reg;
    assign resp_hit     = resp_hit_reg;
    assign resp_way     = resp_way_reg;
    assign resp_way_idx = resp_way_idx_reg;
    assign resp_victim  = resp_victim_reg;

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup (4 ways, 8 sets, 9-bit tags). Stimulus
// pushes expected responses; a negedge monitor pops them on each handshake.
module tb_cache_tag_lookup;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_set;
    logic [8:0] req_tag;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_hit;
    logic [3:0] resp_way;
    logic [1:0] resp_way_idx;
    logic [1:0] resp_victim;
    logic       fill_en;
    logic [2:0] fill_set;
    logic [1:0] fill_way;
    logic [8:0] fill_tag;
    logic       inval_en;
    logic [2:0] inval_set;

    typedef struct {
        logic       hit;
        logic [3:0] way;
        logic [1:0] idx;
        logic [1:0] victim;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   resp_count = 0;
    int   cyc = 0;

    cache_tag_lookup #(.WAYS(4), .SETS(8), .TAG_W(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_set      (req_set),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_hit     (resp_hit),
        .resp_way     (resp_way),
        .resp_way_idx (resp_way_idx),
        .resp_victim  (resp_victim),
        .fill_en      (fill_en),
        .fill_set     (fill_set),
        .fill_way     (fill_way),
        .fill_tag     (fill_tag),
        .inval_en     (inval_en),
        .inval_set    (inval_set)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got hit=%0b way=%b with no expectation", resp_hit, resp_way);
            end else begin
                mon_e = sb.pop_front();
                resp_count++;
                if ({resp_hit, resp_way, resp_way_idx, resp_victim} !==
                    {mon_e.hit, mon_e.way, mon_e.idx, mon_e.victim}) begin
                    errors++;
                    $display("FAIL resp_%0d: got hit=%0b way=%b idx=%0d victim=%0d expected hit=%0b way=%b idx=%0d victim=%0d",
                             resp_count, resp_hit, resp_way, resp_way_idx, resp_victim,
                             mon_e.hit, mon_e.way, mon_e.idx, mon_e.victim);
                end else begin
                    $display("resp %0d: hit=%0b way=%b idx=%0d victim=%0d ok",
                             resp_count, resp_hit, resp_way, resp_way_idx, resp_victim);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, push its expected response, return just after acceptance.
    task automatic issue(input logic [2:0] s, input logic [8:0] t, input logic h,
                         input logic [3:0] w, input logic [1:0] i, input logic [1:0] v);
        exp_t e;
        bit   ok;
        e.hit = h; e.way = w; e.idx = i; e.victim = v;
        sb.push_back(e);
        req_set   = s;
        req_tag   = t;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles (set %0d tag %0h)", s, t);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("req: set=%0d tag=%03h", s, t);
    endtask

    task automatic lookup(input logic [2:0] s, input logic [8:0] t, input logic h,
                          input logic [3:0] w, input logic [1:0] i, input logic [1:0] v);
        issue(s, t, h, w, i, v);
        tick();
    endtask

    task automatic fill(input logic [2:0] s, input logic [1:0] w, input logic [8:0] t);
        fill_en = 1'b1; fill_set = s; fill_way = w; fill_tag = t;
        tick();
        fill_en = 1'b0;
        $display("fill: set=%0d way=%0d tag=%03h", s, w, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b0;
        req_valid = 1'b0; req_set = '0; req_tag = '0;
        resp_ready = 1'b1;
        fill_en = 1'b0; fill_set = '0; fill_way = '0; fill_tag = '0;
        inval_en = 1'b0; inval_set = '0;
        #1 rst = 1'b1;
        #1 check("ready_in_reset", req_ready, 1'b0);
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_hit", resp_hit, 1'b0);
        check("rst_resp_way", resp_way, 4'b0000);
        check("rst_resp_idx", resp_way_idx, 2'd0);
        check("rst_resp_victim", resp_victim, 2'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Empty set misses, victim is the lowest invalid way.
        lookup(3'd3, 9'h055, 1'b0, 4'b0000, 2'd0, 2'd0);

        for (int w = 0; w < 4; w++) fill(3'd3, 2'(w), 9'(9'h010 + w));
        lookup(3'd3, 9'h012, 1'b1, 4'b0100, 2'd2, 2'd0);

        // PLRU walk with the set full.
        lookup(3'd3, 9'h010, 1'b1, 4'b0001, 2'd0, 2'd0);
        lookup(3'd3, 9'h011, 1'b1, 4'b0010, 2'd1, 2'd3);
        lookup(3'd3, 9'h012, 1'b1, 4'b0100, 2'd2, 2'd3);
        lookup(3'd3, 9'h013, 1'b1, 4'b1000, 2'd3, 2'd0);
        lookup(3'd3, 9'h1FF, 1'b0, 4'b0000, 2'd0, 2'd0);
        lookup(3'd3, 9'h010, 1'b1, 4'b0001, 2'd0, 2'd0);
        lookup(3'd3, 9'h1FF, 1'b0, 4'b0000, 2'd0, 2'd2);

        // Held response stays stable across back-pressure and a fill.
        resp_ready = 1'b0;
        issue(3'd3, 9'h011, 1'b1, 4'b0010, 2'd1, 2'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_hit", resp_hit, 1'b1);
            check("hold_way", resp_way, 4'b0010);
            check("hold_victim", resp_victim, 2'd2);
            check("hold_req_ready", req_ready, 1'b0);
            if (i == 0) begin
                fill_en = 1'b1; fill_set = 3'd3; fill_way = 2'd1; fill_tag = 9'h0AA;
            end else if (i == 1) begin
                fill_en = 1'b0;
            end
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        tick();
        tick();

        // Invalidate and fill on the same set in one cycle.
        inval_en = 1'b1; inval_set = 3'd3;
        fill_en = 1'b1; fill_set = 3'd3; fill_way = 2'd1; fill_tag = 9'h0BB;
        tick();
        inval_en = 1'b0; fill_en = 1'b0;
        lookup(3'd3, 9'h0BB, 1'b1, 4'b0010, 2'd1, 2'd0);
        lookup(3'd3, 9'h010, 1'b0, 4'b0000, 2'd0, 2'd0);

        // Another set, then duplicate tags resolve to the lowest way.
        fill(3'd5, 2'd2, 9'h123);
        lookup(3'd5, 9'h123, 1'b1, 4'b0100, 2'd2, 2'd0);
        fill(3'd5, 2'd3, 9'h123);
        lookup(3'd5, 9'h123, 1'b1, 4'b1100, 2'd2, 2'd0);

        // Back-to-back lookups at full throughput.
        issue(3'd5, 9'h123, 1'b1, 4'b1100, 2'd2, 2'd0);
        c0 = cyc;
        issue(3'd5, 9'h1FF, 1'b0, 4'b0000, 2'd0, 2'd0);
        check("throughput_cycles", 32'(cyc - c0), 32'd1);
        tick();

        // Asynchronous reset drops a pending response before the next edge.
        resp_ready = 1'b0;
        issue(3'd5, 9'h123, 1'b1, 4'b1100, 2'd2, 2'd0);
        @(negedge clk);
        check("pre_rst_valid", resp_valid, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", resp_valid, 1'b0);
        sb.delete();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 check("rst_req_ready", req_ready, 1'b0);
        rst = 1'b0;
        tick();
        lookup(3'd3, 9'h0BB, 1'b0, 4'b0000, 2'd0, 2'd0);
        lookup(3'd5, 9'h123, 1'b0, 4'b0000, 2'd0, 2'd0);

        tick();
        tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_tag_lookup.md
# cache_tag_lookup

Parametrised N-way tag store and lookup pipeline for the L1 caches, successor to the two-way combinational hit check. Holds per-set tag, valid and tree-PLRU state. Accepts lookup requests on a valid/ready handshake and returns a registered one-hot hit vector, hit way index and replacement victim one cycle later. Provides fill and set-invalidate write ports used by the cache control FSM.

## Interface
- WAYS, 4: associativity; power of two, 2..16
- SETS, 8: number of sets; power of two, ≥2
- TAG_W, 9: tag width in bits
- Derived: WIDX_W = $clog2(WAYS), SIDX_W = $clog2(SETS)

Ports:
- clk  in  1  sole clock; everything on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  lookup request present
- req_ready  out  1  request accepted this cycle when both high
- req_set  in  SIDX_W  set index
- req_tag  in  TAG_W  tag to match
- resp_valid  out  1  result held
- resp_ready  in  1  consumer takes result
- resp_hit  out  1  any valid way matched
- resp_way  out  WAYS  one-hot matching ways
- resp_way_idx  out  WIDX_W  lowest matching way; 0 on miss
- resp_victim  out  WIDX_W  way to replace in this set
- fill_en  in  1  write tag into a way
- fill_set  in  SIDX_W
- fill_way  in  WIDX_W
- fill_tag  in  TAG_W
- inval_en  in  1  clear all valid bits of inval_set
- inval_set  in  SIDX_W

## Operation
- Storage: tag[SETS][WAYS], valid[SETS][WAYS], plru[SETS][WAYS-1].
- Lookup, evaluated on the accept cycle: match[w] = valid[set][w] && (tag[set][w] == req_tag). The result is registered into resp_*.
- resp_hit = |match. resp_way_idx = lowest set bit of match. Duplicate tags are a controller bug, but the outputs remain well-defined.
- Victim: the lowest-index invalid way if any way in the set is invalid; otherwise the PLRU victim.
- PLRU tree: node 0 is the root, and node n has children 2n+1 and 2n+2. Bit 0 points to the lower half and bit 1 to the upper half. The victim is found by walking from the root.
  - A touch of way w sets every node on w's path to point away from w.
- Touch events:
  - A resp handshake with resp_hit=1 touches resp_way_idx in the set captured with the request.
  - fill_en touches fill_way.
  - If both events hit the same set in the same cycle, only the fill touch is applied. If they hit different sets, both are applied.
- Fill: tag ← fill_tag, valid ← 1.
- Invalidate: valid bits of the set ← 0. PLRU bits are unchanged.
- If fill_en and inval_en target the same set in the same cycle, the invalidate applies first and the fill second. Net result: only fill_way is valid.
- req_ready = !fill_en && !inval_en && (!resp_valid || resp_ready). A lookup never shares a cycle with an array write.
- Held responses are stable: a fill or invalidate after acceptance does not alter resp_*.

## Timing
- Request accepted at edge N → resp_valid=1 from edge N through the edge on which resp_ready=1.
- Throughput is one lookup per cycle when resp_ready is held high and there are no writes.
- Writes are visible to any request accepted at a later edge.
- Reset values:
  - resp_valid=0, resp_hit=0, resp_way=0, resp_way_idx=0, resp_victim=0.
  - All valid=0, all plru=0.
  - Tags are not reset.
- Reset asserted mid-operation drops any pending response immediately, with no handshake.
- While rst=1, req_ready=0.

## Structure
- cache_types gains CACHE_WAYS_DEFAULT, CACHE_SETS_DEFAULT and CACHE_TAG_W=9, consistent with cache_tag.
- Sub-module plru_tree (parameter WAYS) is purely combinational:
  - inputs: state bits, touch way
  - outputs: next state, victim
- Tag comparators reuse compare #(.width(TAG_W)), one instance per way, generated.

## Test plan
- Reset, then a lookup of set 3, tag 0x055 → resp_hit=0, resp_way=0000, resp_victim=0.
- Fill set 3 ways 0..3 with tags 0x010..0x013, then look up tag 0x012 → hit, resp_way=0100, idx=2; on handshake, plru[3] points away from way 2.
- With set 3 full, touch ways 0,1,2,3 in order, then miss on 0x1FF → resp_victim=0. Touch way 0 and miss again → victim=2.
- Hold resp_ready=0 for 3 cycles with a response pending → resp_* unchanged and req_ready=0. Assert fill_en to the same set during the hold → the held resp_hit is unchanged.
- Assert inval_en on set 3 and fill_en set 3 way 1 in the same cycle → the next lookup sees only way 1 valid, and victim=0.
- Assert rst asynchronously while resp_valid=1 → resp_valid falls before the next edge and all sets miss afterwards.
